// File: rtl/div32.sv
// div32: sequential 32-bit unsigned restoring divider, one quotient bit per clock.
module div32 (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        div,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        en,
  output logic        busy,
  output logic        dz
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next_state;
  logic [31:0] rq, dv, rq_nx;
  logic [32:0] rr, rr_nx, t;
  logic [4:0]  cnt;
  logic        start, qbit;
  assign start = div && state != RUN;
  // Trial subtraction: a clear borrow bit means the divisor fits.
  always_comb begin
    t     = {rr[31:0], rq[31]} - {1'b0, dv};
    qbit  = ~t[32];
    rr_nx = qbit ? t : {rr[31:0], rq[31]};
    rq_nx = {rq[30:0], qbit};
  end
  always_ff @(posedge m_clock)
    if (p_reset) state <= IDLE;
    else         state <= next_state;
  always_comb
    next_state = start ? (b == 32'd0 ? DONE : RUN) :
                 state == RUN ? (cnt == 5'd31 ? DONE : RUN) : IDLE;
  always_comb begin
    en   = state == DONE;
    busy = state == RUN;
  end
  always_ff @(posedge m_clock)
    if (p_reset) begin
      rq  <= '0;
      rr  <= '0;
      dv  <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dz  <= 1'b0;
    end else if (start) begin
      if (b != 32'd0) begin
        rq  <= a;
        rr  <= '0;
        dv  <= b;
        cnt <= '0;
        dz  <= 1'b0;
      end else begin
        quo <= '1;
        rem <= a;
        dz  <= 1'b1;
      end
    end else if (state == RUN) begin
      rq  <= rq_nx;
      rr  <= rr_nx;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        quo <= rq_nx;
        rem <= rr_nx[31:0];
      end
    end
endmodule

// File: tb/tb_div32.sv
// tb_div32: directed and random checks of div32 against an arithmetic reference model.
module tb_div32;
  logic        m_clock = 1'b0, p_reset = 1'b1, div = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] quo, rem;
  logic        en, busy, dz;
  int          n_cmp = 0, n_err = 0;

  div32 dut (
    .m_clock(m_clock), .p_reset(p_reset), .a(a), .b(b), .div(div),
    .quo(quo), .rem(rem), .en(en), .busy(busy), .dz(dz)
  );

  always #5 m_clock = ~m_clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned division, divide-by-zero gives all-ones / dividend.
  function automatic logic [64:0] model(input logic [31:0] x, input logic [31:0] y);
    return y == 0 ? {1'b1, 32'hFFFFFFFF, x} : {1'b0, x / y, x % y};
  endfunction

  // One start, then a 40-cycle window; gi injects an ignored start mid-RUN, ri applies reset.
  task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                        input int gi, input int ri);
    int en_cnt = 0, en_first = 0, busy_bad = 0;
    logic [31:0] cq = '0, cr = '0;
    logic cd = 1'b0, exp_busy;
    logic [64:0] m = model(aa, bb);
    @(negedge m_clock);
    a = aa; b = bb; div = 1'b1;
    @(posedge m_clock);
    for (int i = 1; i <= 40; i++) begin
      @(negedge m_clock);
      exp_busy = bb != 0 && i <= 32 && (ri == 0 || i <= ri);
      if (busy !== exp_busy) busy_bad++;
      if (en === 1'b1) begin
        en_cnt++;
        if (en_first == 0) begin
          en_first = i; cq = quo; cr = rem; cd = dz;
        end
      end
      if (ri != 0 && i == ri + 1) begin
        chk({tag, "_rst_outs"}, {quo, rem, en, busy, dz}, '0);
        p_reset = 1'b0;
      end
      div = i == gi;
      a = i == gi ? 32'd7 : $urandom;
      b = i == gi ? 32'd2 : $urandom;
      if (ri != 0 && i == ri) p_reset = 1'b1;
    end
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_en_count"}, en_cnt, ri != 0 ? 0 : 1);
    if (ri == 0) begin
      chk({tag, "_latency"}, en_first, bb == 0 ? 1 : 33);
      chk({tag, "_quo"}, cq, m[63:32]);
      chk({tag, "_rem"}, cr, m[31:0]);
      chk({tag, "_dz"}, cd, m[64]);
    end else begin
      chk({tag, "_quo_after_rst"}, quo, 0);
      chk({tag, "_rem_after_rst"}, rem, 0);
    end
  endtask

  initial begin
    logic [31:0] ca, cb;
    logic [63:0] p;
    int lat;
    repeat (2) @(posedge m_clock);
    @(negedge m_clock);
    chk("reset_state", {quo, rem, en, busy, dz}, '0);
    p_reset = 1'b0;
    run_op("d100_7", 32'd100, 32'd7, 0, 0);
    run_op("dmax_1", 32'hFFFFFFFF, 32'd1, 0, 0);
    run_op("d3_10", 32'd3, 32'd10, 0, 0);
    run_op("d8000_ffff", 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op("d5_0", 32'd5, 32'd0, 0, 0);
    run_op("d9_3", 32'd9, 32'd3, 0, 0);
    run_op("ignore_div", 32'd1000, 32'd3, 10, 0);
    run_op("abort_rst", 32'd1000, 32'd3, 0, 15);
    run_op("d50_5", 32'd50, 32'd5, 0, 0);
    // Back-to-back: div held high, new operands presented in every DONE cycle.
    @(negedge m_clock);
    ca = $urandom; cb = $urandom | 32'd1;
    a = ca; b = cb; div = 1'b1;
    for (int k = 0; k < 600; k++) begin
      lat = 0;
      do begin
        @(negedge m_clock);
        lat++;
      end while (en !== 1'b1 && lat < 100);
      chk("b2b_latency", lat, 33);
      chk("b2b_quo", quo, ca / cb);
      chk("b2b_rem", rem, ca % cb);
      p = 64'(quo) * 64'(cb) + 64'(rem);
      chk("b2b_identity", p, {32'd0, ca});
      chk("b2b_rem_lt_b", rem < cb, 1'b1);
      ca = $urandom >> $urandom_range(0, 16);
      cb = $urandom >> $urandom_range(0, 31);
      if (cb == 0) cb = 32'd1;
      a = ca; b = cb;
    end
    div = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
